// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with registered commit and mispredict flush
module reorder_buffer #(
   parameter int ROB_WIDTH    = 4,
   parameter int EX_REG_WIDTH = 6,
   parameter int NON_REG      = 32
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    DP2ROB_en,
   input  logic [EX_REG_WIDTH-1:0] DP2ROB_rd,
   input  logic                    DP2ROB_is_branch,
   input  logic                    DP2ROB_pred_taken,
   input  logic [31:0]             DP2ROB_alt_pc,
   output logic                    ROB2DP_full,
   output logic [ROB_WIDTH-1:0]    ROB2DP_index,
   input  logic [ROB_WIDTH-1:0]    DP2ROB_q1_idx,
   input  logic [ROB_WIDTH-1:0]    DP2ROB_q2_idx,
   output logic                    ROB2DP_q1_ready,
   output logic [31:0]             ROB2DP_q1_value,
   output logic                    ROB2DP_q2_ready,
   output logic [31:0]             ROB2DP_q2_value,
   input  logic                    CDB2ROB_en,
   input  logic [ROB_WIDTH-1:0]    CDB2ROB_index,
   input  logic [31:0]             CDB2ROB_value,
   input  logic                    CDB2ROB_taken,
   output logic                    ROB2RF_en,
   output logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index,
   output logic [31:0]             ROB2RF_value,
   output logic [EX_REG_WIDTH-1:0] ROB2RF_rd,
   output logic                    ROB2RF_pre_judge,
   output logic                    ROB2IF_jump_en,
   output logic [31:0]             ROB2IF_jump_pc
);

   localparam int ROB_SIZE = 1 << ROB_WIDTH;
   localparam logic [EX_REG_WIDTH-1:0] NON_REG_CODE = EX_REG_WIDTH'(NON_REG);

   logic [ROB_WIDTH-1:0]    head_q, head_d, tail_q, tail_d;
   logic [ROB_WIDTH:0]      count_q, count_d;
   logic [ROB_SIZE-1:0]     busy_q, ready_q, is_branch_q, pred_q, taken_q;
   logic [31:0]             value_q  [ROB_SIZE];
   logic [31:0]             alt_pc_q [ROB_SIZE];
   logic [EX_REG_WIDTH-1:0] rd_q     [ROB_SIZE];

   logic                    rf_en_q, rf_en_d, pre_judge_q, pre_judge_d, jump_en_q, jump_en_d;
   logic [ROB_WIDTH-1:0]    rf_idx_q, rf_idx_d;
   logic [31:0]             rf_value_q, rf_value_d, jump_pc_q, jump_pc_d;
   logic [EX_REG_WIDTH-1:0] rf_rd_q, rf_rd_d;

   logic commit_ok, mispredict, do_pop, do_alloc, do_wb;

   assign ROB2DP_full  = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
   assign ROB2DP_index = tail_q;

   // Operand lookup sees a same-cycle CDB broadcast before it lands in the entry.
   always_comb begin
      ROB2DP_q1_ready = busy_q[DP2ROB_q1_idx] && ready_q[DP2ROB_q1_idx];
      ROB2DP_q1_value = value_q[DP2ROB_q1_idx];
      ROB2DP_q2_ready = busy_q[DP2ROB_q2_idx] && ready_q[DP2ROB_q2_idx];
      ROB2DP_q2_value = value_q[DP2ROB_q2_idx];
      if (CDB2ROB_en && CDB2ROB_index == DP2ROB_q1_idx) begin
         ROB2DP_q1_ready = 1'b1;
         ROB2DP_q1_value = CDB2ROB_value;
      end
      if (CDB2ROB_en && CDB2ROB_index == DP2ROB_q2_idx) begin
         ROB2DP_q2_ready = 1'b1;
         ROB2DP_q2_value = CDB2ROB_value;
      end
   end

   always_comb begin
      commit_ok  = (count_q != '0) && busy_q[head_q] && ready_q[head_q];
      mispredict = commit_ok && is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
      do_pop     = commit_ok && !mispredict;
      do_alloc   = DP2ROB_en && !ROB2DP_full && !mispredict;
      do_wb      = CDB2ROB_en && busy_q[CDB2ROB_index] && !mispredict;

      head_d      = do_pop   ? head_q + ROB_WIDTH'(1) : head_q;
      tail_d      = do_alloc ? tail_q + ROB_WIDTH'(1) : tail_q;
      count_d     = count_q + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(do_pop);
      rf_en_d     = do_pop;
      rf_idx_d    = rf_idx_q;
      rf_value_d  = rf_value_q;
      rf_rd_d     = rf_rd_q;
      pre_judge_d = 1'b1;
      jump_en_d   = 1'b0;
      jump_pc_d   = jump_pc_q;

      if (do_pop) begin
         rf_idx_d   = head_q;
         rf_value_d = value_q[head_q];
         rf_rd_d    = rd_q[head_q];
      end
      if (mispredict) begin
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         pre_judge_d = 1'b0;
         jump_en_d   = 1'b1;
         jump_pc_d   = alt_pc_q[head_q];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         busy_q      <= '0;
         ready_q     <= '0;
         is_branch_q <= '0;
         pred_q      <= '0;
         taken_q     <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            value_q[i]  <= '0;
            alt_pc_q[i] <= '0;
            rd_q[i]     <= NON_REG_CODE;
         end
         rf_en_q     <= 1'b0;
         rf_idx_q    <= '0;
         rf_value_q  <= '0;
         rf_rd_q     <= NON_REG_CODE;
         pre_judge_q <= 1'b1;
         jump_en_q   <= 1'b0;
         jump_pc_q   <= '0;
      end else if (!rdy_in) begin
         rf_en_q     <= 1'b0;
         pre_judge_q <= 1'b1;
         jump_en_q   <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         rf_en_q     <= rf_en_d;
         rf_idx_q    <= rf_idx_d;
         rf_value_q  <= rf_value_d;
         rf_rd_q     <= rf_rd_d;
         pre_judge_q <= pre_judge_d;
         jump_en_q   <= jump_en_d;
         jump_pc_q   <= jump_pc_d;
         if (mispredict) begin
            busy_q <= '0;
         end else begin
            if (do_pop) busy_q[head_q] <= 1'b0;
            if (do_wb) begin
               ready_q[CDB2ROB_index] <= 1'b1;
               value_q[CDB2ROB_index] <= CDB2ROB_value;
               taken_q[CDB2ROB_index] <= CDB2ROB_taken;
            end
            if (do_alloc) begin
               busy_q[tail_q]      <= 1'b1;
               ready_q[tail_q]     <= 1'b0;
               rd_q[tail_q]        <= DP2ROB_rd;
               is_branch_q[tail_q] <= DP2ROB_is_branch;
               pred_q[tail_q]      <= DP2ROB_pred_taken;
               alt_pc_q[tail_q]    <= DP2ROB_alt_pc;
            end
         end
      end
   end

   assign ROB2RF_en        = rf_en_q;
   assign ROB2RF_ROB_index = rf_idx_q;
   assign ROB2RF_value     = rf_value_q;
   assign ROB2RF_rd        = rf_rd_q;
   assign ROB2RF_pre_judge = pre_judge_q;
   assign ROB2IF_jump_en   = jump_en_q;
   assign ROB2IF_jump_pc   = jump_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed bench for reorder_buffer with a queue-based reference model
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in;
   logic        DP2ROB_en, DP2ROB_is_branch, DP2ROB_pred_taken;
   logic [5:0]  DP2ROB_rd;
   logic [31:0] DP2ROB_alt_pc;
   logic        ROB2DP_full;
   logic [3:0]  ROB2DP_index, DP2ROB_q1_idx, DP2ROB_q2_idx;
   logic        ROB2DP_q1_ready, ROB2DP_q2_ready;
   logic [31:0] ROB2DP_q1_value, ROB2DP_q2_value;
   logic        CDB2ROB_en, CDB2ROB_taken;
   logic [3:0]  CDB2ROB_index;
   logic [31:0] CDB2ROB_value;
   logic        ROB2RF_en, ROB2RF_pre_judge, ROB2IF_jump_en;
   logic [3:0]  ROB2RF_ROB_index;
   logic [31:0] ROB2RF_value, ROB2IF_jump_pc;
   logic [5:0]  ROB2RF_rd;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .DP2ROB_en(DP2ROB_en), .DP2ROB_rd(DP2ROB_rd), .DP2ROB_is_branch(DP2ROB_is_branch),
      .DP2ROB_pred_taken(DP2ROB_pred_taken), .DP2ROB_alt_pc(DP2ROB_alt_pc),
      .ROB2DP_full(ROB2DP_full), .ROB2DP_index(ROB2DP_index),
      .DP2ROB_q1_idx(DP2ROB_q1_idx), .DP2ROB_q2_idx(DP2ROB_q2_idx),
      .ROB2DP_q1_ready(ROB2DP_q1_ready), .ROB2DP_q1_value(ROB2DP_q1_value),
      .ROB2DP_q2_ready(ROB2DP_q2_ready), .ROB2DP_q2_value(ROB2DP_q2_value),
      .CDB2ROB_en(CDB2ROB_en), .CDB2ROB_index(CDB2ROB_index),
      .CDB2ROB_value(CDB2ROB_value), .CDB2ROB_taken(CDB2ROB_taken),
      .ROB2RF_en(ROB2RF_en), .ROB2RF_ROB_index(ROB2RF_ROB_index),
      .ROB2RF_value(ROB2RF_value), .ROB2RF_rd(ROB2RF_rd),
      .ROB2RF_pre_judge(ROB2RF_pre_judge),
      .ROB2IF_jump_en(ROB2IF_jump_en), .ROB2IF_jump_pc(ROB2IF_jump_pc)
   );

   always #5 clk_in = ~clk_in;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Reference: the ROB is a plain FIFO of in-flight instructions tagged with their slot number.
   typedef struct {
      logic [3:0]  idx;
      logic [5:0]  rd;
      logic        br, pred, rdy, taken;
      logic [31:0] alt, val;
   } ent_t;

   ent_t        mq[$];
   ent_t        ne;
   logic [3:0]  m_tail;
   logic        e_en, e_pj, e_jen, was_full, flush;
   logic [3:0]  e_idx;
   logic [31:0] e_val, e_jpc;
   logic [5:0]  e_rd;

   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mq.delete();
         m_tail = 0; e_en = 0; e_idx = 0; e_val = 0; e_rd = 6'd32;
         e_pj = 1; e_jen = 0; e_jpc = 0;
      end else begin
         e_en = 0; e_jen = 0; e_pj = 1;
         if (rdy_in) begin
            was_full = (mq.size() == 16);
            flush = 0;
            if (mq.size() > 0 && mq[0].rdy) begin
               if (mq[0].br && mq[0].taken != mq[0].pred) begin
                  e_pj = 0; e_jen = 1; e_jpc = mq[0].alt; flush = 1;
               end else begin
                  e_en = 1; e_idx = mq[0].idx; e_val = mq[0].val; e_rd = mq[0].rd;
                  void'(mq.pop_front());
               end
            end
            if (flush) begin
               mq.delete();
               m_tail = 0;
            end else begin
               if (CDB2ROB_en)
                  foreach (mq[k])
                     if (mq[k].idx == CDB2ROB_index) begin
                        mq[k].rdy = 1; mq[k].val = CDB2ROB_value; mq[k].taken = CDB2ROB_taken;
                     end
               if (DP2ROB_en && !was_full) begin
                  ne.idx = m_tail; ne.rd = DP2ROB_rd; ne.br = DP2ROB_is_branch;
                  ne.pred = DP2ROB_pred_taken; ne.alt = DP2ROB_alt_pc;
                  ne.rdy = 0; ne.taken = 0; ne.val = 0;
                  mq.push_back(ne);
                  m_tail = m_tail + 4'd1;
               end
            end
         end
      end
   end

   function automatic void qmodel(input logic [3:0] qi, output logic r, output logic [31:0] v);
      r = 0; v = 0;
      if (CDB2ROB_en && CDB2ROB_index == qi) begin
         r = 1; v = CDB2ROB_value;
      end else
         foreach (mq[k])
            if (mq[k].idx == qi && mq[k].rdy) begin
               r = 1; v = mq[k].val;
            end
   endfunction

   logic        mr;
   logic [31:0] mv;

   always @(negedge clk_in) begin
      chk("full", 32'(ROB2DP_full), 32'(mq.size() == 16));
      chk("index", 32'(ROB2DP_index), 32'(m_tail));
      chk("rf_en", 32'(ROB2RF_en), 32'(e_en));
      chk("rf_idx", 32'(ROB2RF_ROB_index), 32'(e_idx));
      chk("rf_value", ROB2RF_value, e_val);
      chk("rf_rd", 32'(ROB2RF_rd), 32'(e_rd));
      chk("pre_judge", 32'(ROB2RF_pre_judge), 32'(e_pj));
      chk("jump_en", 32'(ROB2IF_jump_en), 32'(e_jen));
      chk("jump_pc", ROB2IF_jump_pc, e_jpc);
      qmodel(DP2ROB_q1_idx, mr, mv);
      chk("q1_ready", 32'(ROB2DP_q1_ready), 32'(mr));
      if (mr) chk("q1_value", ROB2DP_q1_value, mv);
      qmodel(DP2ROB_q2_idx, mr, mv);
      chk("q2_ready", 32'(ROB2DP_q2_ready), 32'(mr));
      if (mr) chk("q2_value", ROB2DP_q2_value, mv);
   end

   task automatic idle();
      DP2ROB_en = 0; DP2ROB_rd = 6'd32; DP2ROB_is_branch = 0; DP2ROB_pred_taken = 0;
      DP2ROB_alt_pc = 0; CDB2ROB_en = 0; CDB2ROB_index = 0; CDB2ROB_value = 0;
      CDB2ROB_taken = 0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic alloc(input logic [5:0] rd, input logic br, input logic pred, input logic [31:0] alt);
      DP2ROB_en = 1; DP2ROB_rd = rd; DP2ROB_is_branch = br;
      DP2ROB_pred_taken = pred; DP2ROB_alt_pc = alt;
   endtask

   task automatic cdb(input logic [3:0] idx, input logic [31:0] val, input logic tk);
      CDB2ROB_en = 1; CDB2ROB_index = idx; CDB2ROB_value = val; CDB2ROB_taken = tk;
   endtask

   task automatic do_reset();
      @(posedge clk_in);
      #2 rst_in = 0;
      idle();
      #4 rst_in = 1;
      tick();
   endtask

   initial begin
      rdy_in = 1; DP2ROB_q1_idx = 0; DP2ROB_q2_idx = 0;
      idle();
      #1 rst_in = 0;
      #7;
      chk("rst_full", 32'(ROB2DP_full), 0);
      chk("rst_index", 32'(ROB2DP_index), 0);
      chk("rst_rf_en", 32'(ROB2RF_en), 0);
      chk("rst_pre_judge", 32'(ROB2RF_pre_judge), 1);
      chk("rst_rd", 32'(ROB2RF_rd), 32);
      #4 rst_in = 1;

      // in-order commit behind an unfinished head
      for (int i = 0; i < 3; i++) begin
         alloc(6'(i + 1), 0, 0, 0);
         chk("t1_alloc_index", 32'(ROB2DP_index), 32'(i));
         tick();
      end
      idle();
      chk("t1_index3", 32'(ROB2DP_index), 3);
      cdb(4'd1, 32'h22, 0); tick(); idle(); tick();
      chk("t1_no_commit", 32'(ROB2RF_en), 0);
      cdb(4'd0, 32'h11, 0); tick(); idle();
      chk("t1_latency", 32'(ROB2RF_en), 0);
      tick();
      chk("t1_c0_en", 32'(ROB2RF_en), 1);
      chk("t1_c0_idx", 32'(ROB2RF_ROB_index), 0);
      chk("t1_c0_rd", 32'(ROB2RF_rd), 1);
      chk("t1_c0_val", ROB2RF_value, 32'h11);
      tick();
      chk("t1_c1_en", 32'(ROB2RF_en), 1);
      chk("t1_c1_idx", 32'(ROB2RF_ROB_index), 1);
      chk("t1_c1_rd", 32'(ROB2RF_rd), 2);
      chk("t1_c1_val", ROB2RF_value, 32'h22);
      tick();
      chk("t1_c2_wait", 32'(ROB2RF_en), 0);
      rdy_in = 0; alloc(6'd4, 0, 0, 0); tick();
      chk("t1_hold_index", 32'(ROB2DP_index), 3);
      rdy_in = 1; idle();

      // fill, overflow, wrap
      do_reset();
      for (int i = 0; i < 16; i++) begin
         alloc(6'(i), 0, 0, 0);
         chk("t2_fill_index", 32'(ROB2DP_index), 32'(i));
         tick();
      end
      chk("t2_full", 32'(ROB2DP_full), 1);
      chk("t2_tail_wrap", 32'(ROB2DP_index), 0);
      alloc(6'd9, 0, 0, 0); tick(); idle();
      chk("t2_17th_full", 32'(ROB2DP_full), 1);
      chk("t2_17th_index", 32'(ROB2DP_index), 0);
      cdb(4'd0, 32'h100, 0); tick(); idle(); tick();
      chk("t2_commit_en", 32'(ROB2RF_en), 1);
      chk("t2_commit_rd", 32'(ROB2RF_rd), 0);
      chk("t2_not_full", 32'(ROB2DP_full), 0);
      alloc(6'd7, 0, 0, 0); tick(); idle();
      chk("t2_wrap_full", 32'(ROB2DP_full), 1);
      chk("t2_wrap_index", 32'(ROB2DP_index), 1);

      // mispredict flush beats a same-cycle allocation
      do_reset();
      alloc(6'd32, 1, 0, 32'h1000); tick();
      alloc(6'd5, 0, 0, 0); tick(); idle();
      cdb(4'd1, 32'h55, 0); tick();
      cdb(4'd0, 32'h0, 1); tick(); idle();
      alloc(6'd6, 0, 0, 0); tick(); idle();
      chk("t3_pre_judge", 32'(ROB2RF_pre_judge), 0);
      chk("t3_jump_en", 32'(ROB2IF_jump_en), 1);
      chk("t3_jump_pc", ROB2IF_jump_pc, 32'h1000);
      chk("t3_rf_en", 32'(ROB2RF_en), 0);
      chk("t3_flush_index", 32'(ROB2DP_index), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_no_commit", 32'(ROB2RF_en), 0);
         chk("t3_jump_off", 32'(ROB2IF_jump_en), 0);
      end

      // correctly predicted branch retires normally
      do_reset();
      alloc(6'd32, 1, 1, 32'h2000); tick(); idle();
      cdb(4'd0, 32'h0, 1); tick(); idle(); tick();
      chk("t4_rf_en", 32'(ROB2RF_en), 1);
      chk("t4_rd", 32'(ROB2RF_rd), 32);
      chk("t4_pre_judge", 32'(ROB2RF_pre_judge), 1);
      chk("t4_jump_en", 32'(ROB2IF_jump_en), 0);

      // operand bypass, then async reset with entries in flight
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alloc(6'(i + 1), 0, 0, 0); tick();
      end
      idle();
      DP2ROB_q1_idx = 3; DP2ROB_q2_idx = 2;
      cdb(4'd3, 32'hDEAD, 0);
      #1;
      chk("t5_byp_ready", 32'(ROB2DP_q1_ready), 1);
      chk("t5_byp_value", ROB2DP_q1_value, 32'hDEAD);
      chk("t5_q2_ready", 32'(ROB2DP_q2_ready), 0);
      tick(); idle();
      chk("t5_stored_ready", 32'(ROB2DP_q1_ready), 1);
      chk("t5_stored_value", ROB2DP_q1_value, 32'hDEAD);
      alloc(6'd5, 0, 0, 0); tick(); idle();
      chk("t6_pre_index", 32'(ROB2DP_index), 5);
      #2 rst_in = 0;
      #1;
      chk("t6_full", 32'(ROB2DP_full), 0);
      chk("t6_index", 32'(ROB2DP_index), 0);
      chk("t6_rf_en", 32'(ROB2RF_en), 0);
      chk("t6_pre_judge", 32'(ROB2RF_pre_judge), 1);
      chk("t6_rd", 32'(ROB2RF_rd), 32);
      chk("t6_value", ROB2RF_value, 0);
      chk("t6_q1_ready", 32'(ROB2DP_q1_ready), 0);
      #2 rst_in = 1;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
